// File: rtl/tcore_mem_arbiter_pkg.sv
// tcore_mem_arbiter_pkg: shared types, widths and byte-mask helper for the main-memory arbiter
package tcore_mem_arbiter_pkg;

    localparam int BLK_SIZE = 128;
    localparam int XLEN     = 32;
    localparam int MASK_W   = BLK_SIZE / 8;

    typedef enum logic [1:0] {NO_SIZE, BYTE, HALF_WORD, WORD} size_e;
    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_RESP} mem_arb_state_e;
    typedef enum logic {GNT_ICACHE, GNT_DCACHE} mem_gnt_e;

    typedef struct packed {
        logic            valid;
        logic            ready;
        logic [XLEN-1:0] addr;
        logic            uncached;
    } ilowX_req_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [BLK_SIZE-1:0] blk;
    } ilowX_res_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [XLEN-1:0]     addr;
        size_e               rw_size;
        logic                rw;
        logic [BLK_SIZE-1:0] data;
        logic                uncached;
    } dlowX_req_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic [BLK_SIZE-1:0] data;
    } dlowX_res_t;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     addr;
        logic [BLK_SIZE-1:0] data;
        logic [MASK_W-1:0]   rw;
    } mem_req_t;

    // Low address bits are aligned to the access size before shifting, so no lane ever passes bit 15.
    function automatic logic [MASK_W-1:0] blk_byte_mask(input logic [3:0] addr, input size_e size,
                                                        input logic rw, input logic uncached);
        return !rw                ? 16'h0000 :
               !uncached          ? 16'hFFFF :
               size == BYTE       ? 16'h0001 << addr :
               size == HALF_WORD  ? 16'h0003 << {addr[3:1], 1'b0} :
               size == WORD       ? 16'h000F << {addr[3:2], 2'b00} :
                                    16'h0000;
    endfunction

endpackage

// File: rtl/tcore_mem_arbiter_rr_arb2.sv
// tcore_rr_arb2: 2-way round-robin grant; req[0]=icache, req[1]=dcache, last_grant held by the parent, gnt combinational
module tcore_rr_arb2
    import tcore_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  mem_gnt_e   last_grant,
    output mem_gnt_e   gnt
);

    // On conflict the side that did not win last time goes next.
    always_comb gnt = (req[1] && (!req[0] || last_grant == GNT_ICACHE)) ? GNT_DCACHE : GNT_ICACHE;

endmodule

// File: rtl/tcore_mem_arbiter.sv
// tcore_mem_arbiter: shares the main-memory port between icache (iarb_*) and dcache (darb_*) miss paths, one block transaction at a time
//  clk_i, rst_ni (sync, active-low); iarb_req_i/iarb_res_o icache side; darb_req_i/darb_res_o dcache side;
//  mem_req_o/mem_ready_i request to memory; mem_res_valid_i/mem_res_data_i memory response pulse
module tcore_mem_arbiter
    import tcore_mem_arbiter_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  ilowX_req_t          iarb_req_i,
    output ilowX_res_t          iarb_res_o,
    input  dlowX_req_t          darb_req_i,
    output dlowX_res_t          darb_res_o,
    output mem_req_t            mem_req_o,
    input  logic                mem_ready_i,
    input  logic                mem_res_valid_i,
    input  logic [BLK_SIZE-1:0] mem_res_data_i
);

    mem_arb_state_e      state;
    mem_gnt_e            last_grant, grant, gnt;
    logic [XLEN-1:0]     addr_q, sel_addr;
    logic [BLK_SIZE-1:0] data_q, blk_q;
    logic [MASK_W-1:0]   mask_q;
    logic                wr_q, sel_uc, pick_d;
    logic                unused_ready;

    assign unused_ready = iarb_req_i.ready ^ darb_req_i.ready;

    tcore_rr_arb2 u_rr (
        .req        ({darb_req_i.valid, iarb_req_i.valid}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    always_comb begin
        pick_d   = gnt == GNT_DCACHE;
        sel_addr = pick_d ? darb_req_i.addr : iarb_req_i.addr;
        sel_uc   = pick_d ? darb_req_i.uncached : iarb_req_i.uncached;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= ARB_IDLE;
            last_grant <= GNT_ICACHE;
            grant      <= GNT_ICACHE;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            wr_q       <= 1'b0;
            blk_q      <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (iarb_req_i.valid || darb_req_i.valid) begin
                    state  <= ARB_REQ;
                    grant  <= gnt;
                    addr_q <= sel_uc ? sel_addr : {sel_addr[XLEN-1:4], 4'h0};
                    data_q <= pick_d ? darb_req_i.data : '0;
                    mask_q <= pick_d ? blk_byte_mask(darb_req_i.addr[3:0], darb_req_i.rw_size,
                                                     darb_req_i.rw, darb_req_i.uncached) : '0;
                    wr_q   <= pick_d && darb_req_i.rw;
                end
                ARB_REQ:  if (mem_ready_i) state <= ARB_WAIT;
                ARB_WAIT: if (mem_res_valid_i) begin
                    blk_q <= mem_res_data_i;
                    state <= ARB_RESP;
                end
                ARB_RESP: begin
                    last_grant <= grant;
                    state      <= ARB_IDLE;
                end
                default:  state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        iarb_res_o = '{valid: state == ARB_RESP && grant == GNT_ICACHE, ready: state == ARB_IDLE, blk: blk_q};
        darb_res_o = '{valid: state == ARB_RESP && grant == GNT_DCACHE, ready: state == ARB_IDLE,
                       data: wr_q ? '0 : blk_q};
        mem_req_o  = '{valid: state == ARB_REQ, addr: addr_q, data: data_q, rw: mask_q};
    end

endmodule
